spi_cmd_regbank: RTL and testbench

- Parametrised SPI command decoder and register bank; successor to the fixed Ton/Toff/Ip/waveform command block.
- Takes the byte stream from spi_slave_driver (rx_byte/rx_valid, tx_byte, cs_n). Decodes indexed write, register readback, start/stop and feedback-read commands.
- Exposes NUM_REGS parameter registers, each with an extended update-ack pulse for crossing into slower domains.
- Adds atomic multi-byte commit, frame abort on cs_n rise, and register readback.

---
 rtl/spi_cmd_regbank.sv | 210 +++++++++++++++++++++
 tb/tb_spi_cmd_regbank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regbank.sv
// SPI command decoder and parameter register bank with extended update acks.
// Optional `define SPI_CMD_CHECKSUM_EN adds XOR checksum bytes to write, read and feedback frames.
module spi_cmd_regbank #(
  parameter int NUM_REGS   = 4,
  parameter int REG_BYTES  = 2,
  parameter int FB_BYTES   = 4,
  parameter int ACK_CYCLES = 4,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = {16'd30, 16'd0, 16'd20, 16'd80}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cs_n,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_valid,
  output logic [7:0]                      tx_byte,
  output logic [NUM_REGS*REG_BYTES*8-1:0] reg_data,
  output logic [NUM_REGS-1:0]             reg_ack,
  output logic                            start_ack,
  output logic                            stop_ack,
  input  logic [FB_BYTES*8-1:0]           fb_data_async,
  input  logic                            fb_valid_async,
  output logic                            cmd_err
);

  localparam int RW = REG_BYTES * 8;
  localparam int AW = $clog2(ACK_CYCLES + 1);

`ifdef SPI_CMD_CHECKSUM_EN
  localparam int CSUM = 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_WR, S_RD, S_FB, S_CHK} state_t;
`else
  localparam int CSUM = 0;
  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_WR, S_RD, S_FB} state_t;
`endif

  state_t                state;
  logic [3:0]            idx;
  logic [2:0]            k;
  logic [7:0]            csum;
  logic [RW-1:0]         shadow;
  logic [RW-1:0]         wr_word;
  logic                  cs_q;
  logic                  abort;
  logic [2:0]            fb_sync;
  logic [FB_BYTES*8-1:0] fb_snapshot;
  logic [AW-1:0]         reg_cnt [NUM_REGS];
  logic [AW-1:0]         start_cnt;
  logic [AW-1:0]         stop_cnt;
  logic [7:0]            first_byte;
  logic [7:0]            nxt_byte;
  logic                  rd_last;
  logic                  nxt_is_data;

  function automatic logic [7:0] pick_byte(input logic [NUM_REGS*RW-1:0] regs,
                                           input logic [FB_BYTES*8-1:0] fb,
                                           input logic from_fb, input logic [3:0] ri,
                                           input int b);
    pick_byte = 8'hFF;
    if (from_fb) begin
      for (int j = 0; j < FB_BYTES; j++)
        if (j == b) pick_byte = fb[j*8 +: 8];
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        for (int j = 0; j < REG_BYTES; j++)
          if (r == int'(ri) && j == b) pick_byte = regs[r*RW + j*8 +: 8];
    end
  endfunction

  // A cs_n rising edge aborts any frame in progress, even with rx_valid in the same cycle
  assign abort = cs_n && !cs_q && (state != S_IDLE);

  always_comb begin
    wr_word = shadow;
    for (int j = 0; j < REG_BYTES; j++)
      if (j == int'(k)) wr_word[j*8 +: 8] = rx_byte;
  end

  assign first_byte  = pick_byte(reg_data, fb_snapshot, rx_byte == 8'hAB, rx_byte[3:0], 0);
  assign nxt_byte    = pick_byte(reg_data, fb_snapshot, state == S_FB, idx, int'(k) + 1);
  assign rd_last     = int'(k) == ((state == S_FB) ? FB_BYTES : REG_BYTES) + CSUM - 1;
  assign nxt_is_data = int'(k) + 1 < ((state == S_FB) ? FB_BYTES : REG_BYTES);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) reg_ack[r] = (reg_cnt[r] != '0);
  end
  assign start_ack = (start_cnt != '0);
  assign stop_ack  = (stop_cnt != '0);

  always_ff @(posedge clk)
    if (state == S_WR && rx_valid && !abort) shadow <= wr_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_sync     <= '0;
      fb_snapshot <= '0;
    end else begin
      fb_sync <= {fb_sync[1:0], fb_valid_async};
      if (cs_n && fb_sync[2]) fb_snapshot <= fb_data_async;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      k         <= '0;
      csum      <= '0;
      cs_q      <= 1'b1;
      tx_byte   <= 8'hFF;
      cmd_err   <= 1'b0;
      reg_data  <= RESET_VALUES;
      start_cnt <= '0;
      stop_cnt  <= '0;
      for (int r = 0; r < NUM_REGS; r++) reg_cnt[r] <= '0;
    end else begin
      cs_q    <= cs_n;
      cmd_err <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++)
        if (reg_cnt[r] != '0) reg_cnt[r] <= reg_cnt[r] - 1'b1;
      if (start_cnt != '0) start_cnt <= start_cnt - 1'b1;
      if (stop_cnt != '0) stop_cnt <= stop_cnt - 1'b1;

      if (abort) begin
        state   <= S_IDLE;
        tx_byte <= 8'hFF;
        cmd_err <= 1'b1;
        k       <= '0;
      end else begin
        case (state)
          S_IDLE: if (rx_valid) begin
            idx  <= rx_byte[3:0];
            k    <= '0;
            csum <= rx_byte;
            if (rx_byte == 8'h06) state <= S_START;
            else if (rx_byte == 8'h04) state <= S_STOP;
            else if (rx_byte == 8'hAB) begin
              state   <= S_FB;
              tx_byte <= first_byte;
              csum    <= rx_byte ^ first_byte;
            end else if (rx_byte[7:4] == 4'h8 && int'(rx_byte[3:0]) < NUM_REGS) begin
              state <= S_WR;
            end else if (rx_byte[7:4] == 4'h4 && int'(rx_byte[3:0]) < NUM_REGS) begin
              state   <= S_RD;
              tx_byte <= first_byte;
              csum    <= rx_byte ^ first_byte;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          S_START: begin
            start_cnt <= AW'(ACK_CYCLES);
            state     <= S_IDLE;
          end
          S_STOP: begin
            stop_cnt <= AW'(ACK_CYCLES);
            state    <= S_IDLE;
          end
          S_WR: if (rx_valid) begin
            csum <= csum ^ rx_byte;
            if (int'(k) == REG_BYTES - 1) begin
`ifdef SPI_CMD_CHECKSUM_EN
              state <= S_CHK;
`else
              for (int r = 0; r < NUM_REGS; r++)
                if (r == int'(idx)) begin
                  reg_data[r*RW +: RW] <= wr_word;
                  reg_cnt[r]           <= AW'(ACK_CYCLES);
                end
              state <= S_IDLE;
`endif
            end else begin
              k <= k + 1'b1;
            end
          end
`ifdef SPI_CMD_CHECKSUM_EN
          S_CHK: if (rx_valid) begin
            if (rx_byte == csum) begin
              for (int r = 0; r < NUM_REGS; r++)
                if (r == int'(idx)) begin
                  reg_data[r*RW +: RW] <= shadow;
                  reg_cnt[r]           <= AW'(ACK_CYCLES);
                end
            end else begin
              cmd_err <= 1'b1;
            end
            state <= S_IDLE;
          end
`endif
          S_RD, S_FB: if (rx_valid) begin
            if (rd_last) begin
              tx_byte <= 8'hFF;
              state   <= S_IDLE;
            end else begin
              k <= k + 1'b1;
              // Past the data bytes the only remaining slot is the checksum
              if (nxt_is_data) begin
                tx_byte <= nxt_byte;
                csum    <= csum ^ nxt_byte;
              end else begin
                tx_byte <= csum;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_regbank.sv
// Bench for spi_cmd_regbank: frame vector table plus hand sequences, tx bytes checked via a scoreboard queue.
module tb_spi_cmd_regbank;
  localparam int NR = 4;
  localparam int RB = 2;
`ifdef SPI_CMD_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic [63:0] reg_data;
  logic [3:0]  reg_ack;
  logic        start_ack, stop_ack, cmd_err;
  logic [31:0] fb_data_async = 32'h0;
  logic        fb_valid_async = 1'b0;

  spi_cmd_regbank dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .reg_data(reg_data), .reg_ack(reg_ack), .start_ack(start_ack),
    .stop_ack(stop_ack), .fb_data_async(fb_data_async), .fb_valid_async(fb_valid_async),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ack_cyc [NR];
  int start_cyc, stop_cyc, err_cyc;
  logic [7:0] exp_tx [$];
  logic [63:0] cur_img;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    logic [63:0] img;
    logic [3:0]  ack;
    int          start;
    int          stop;
    int          err;
  } vec_t;
  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int r = 0; r < NR; r++) if (reg_ack[r]) ack_cyc[r]++;
    if (start_ack) start_cyc++;
    if (stop_ack) stop_cyc++;
    if (cmd_err) err_cyc++;
  end

  always @(posedge clk) begin
    logic [7:0] e;
    if (rx_valid) begin
      #1;
      if (exp_tx.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_underflow: got %h with no expected byte queued", tx_byte);
      end else begin
        e = exp_tx.pop_front();
        check("tx_byte", {56'h0, tx_byte}, {56'h0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] etx);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    exp_tx.push_back(etx);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    rx_valid = 1'b0;
    for (int r = 0; r < NR; r++) ack_cyc[r] = 0;
    start_cyc = 0;
    stop_cyc  = 0;
    err_cyc   = 0;
    cs_n      = 1'b0;
  endtask

  task automatic frame_end();
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] op, input logic [15:0] d);
    send(op, 8'hFF);
    send(d[7:0], 8'hFF);
    send(d[15:8], 8'hFF);
    if (CS != 0) send(op ^ d[7:0] ^ d[15:8], 8'hFF);
  endtask

  task automatic rd(input logic [7:0] op, input logic [31:0] src, input int n);
    logic [7:0] x;
    logic [7:0] e;
    x = op ^ src[7:0];
    send(op, src[7:0]);
    for (int j = 1; j <= n + CS; j++) begin
      if (j < n) begin
        e = src[j*8 +: 8];
        x = x ^ e;
      end else if (j == n && CS != 0) e = x;
      else e = 8'hFF;
      send(8'h00, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h81, 16'h1234, 64'h001E_0000_1234_0050, 4'b0010, 0, 0, 0};
    vt[1] = '{8'h41, 16'h0000, 64'h001E_0000_1234_0050, 4'b0000, 0, 0, 0};
    vt[2] = '{8'h83, 16'hABCD, 64'hABCD_0000_1234_0050, 4'b1000, 0, 0, 0};
    vt[3] = '{8'h40, 16'h0000, 64'hABCD_0000_1234_0050, 4'b0000, 0, 0, 0};
    vt[4] = '{8'h85, 16'h0000, 64'hABCD_0000_1234_0050, 4'b0000, 0, 0, 1};
    vt[5] = '{8'h55, 16'h0000, 64'hABCD_0000_1234_0050, 4'b0000, 0, 0, 1};
    vt[6] = '{8'h80, 16'h0010, 64'hABCD_0000_1234_0010, 4'b0001, 0, 0, 0};
    vt[7] = '{8'h43, 16'h0000, 64'hABCD_0000_1234_0010, 4'b0000, 0, 0, 0};
    vt[8] = '{8'h06, 16'h0000, 64'hABCD_0000_1234_0010, 4'b0000, 4, 0, 0};
    vt[9] = '{8'h04, 16'h0000, 64'hABCD_0000_1234_0010, 4'b0000, 0, 4, 0};

    cur_img = 64'h001E_0000_0014_0050;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_reg_data", reg_data, cur_img);
    check("rst_tx_byte", {56'h0, tx_byte}, 64'hFF);
    check("rst_acks", {58'h0, reg_ack, start_ack, stop_ack}, 64'h0);
    check("rst_cmd_err", {63'h0, cmd_err}, 64'h0);

    for (int v = 0; v < 10; v++) begin
      frame_begin();
      if (vt[v].err != 0) send(vt[v].op, 8'hFF);
      else if (vt[v].op[7:4] == 4'h8) wr(vt[v].op, vt[v].data);
      else if (vt[v].op[7:4] == 4'h4) rd(vt[v].op, {16'h0, cur_img[int'(vt[v].op[1:0])*16 +: 16]}, RB);
      else send(vt[v].op, 8'hFF);
      frame_end();
      check($sformatf("v%0d_reg_data", v), reg_data, vt[v].img);
      for (int r = 0; r < NR; r++)
        check($sformatf("v%0d_ack%0d_cycles", v, r), 64'(ack_cyc[r]), vt[v].ack[r] ? 64'd4 : 64'd0);
      check($sformatf("v%0d_start_cycles", v), 64'(start_cyc), 64'(vt[v].start));
      check($sformatf("v%0d_stop_cycles", v), 64'(stop_cyc), 64'(vt[v].stop));
      check($sformatf("v%0d_err_cycles", v), 64'(err_cyc), 64'(vt[v].err));
      cur_img = vt[v].img;
    end

    // Abort mid-write; the final data byte arrives in the same cycle as the cs_n rise
    frame_begin();
    send(8'h81, 8'hFF);
    send(8'h55, 8'hFF);
    @(negedge clk);
    rx_byte = 8'h66; rx_valid = 1'b1; cs_n = 1'b1;
    exp_tx.push_back(8'hFF);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_reg_data", reg_data, cur_img);
    check("abort_err_cycles", 64'(err_cyc), 64'd1);
    check("abort_ack1_cycles", 64'(ack_cyc[1]), 64'd0);
    frame_begin();
    send(8'h06, 8'hFF);
    frame_end();
    check("after_abort_start_cycles", 64'(start_cyc), 64'd4);
    check("after_abort_err_cycles", 64'(err_cyc), 64'd0);

    // Feedback snapshot taken while idle, held against mid-frame changes
    @(negedge clk);
    fb_data_async = 32'hA1B2C3D4; fb_valid_async = 1'b1;
    repeat (6) @(negedge clk);
    fb_valid_async = 1'b0;
    frame_begin();
    @(negedge clk);
    fb_data_async = 32'hDEADBEEF; fb_valid_async = 1'b1;
    rd(8'hAB, 32'hA1B2C3D4, 4);
    frame_end();
    check("fb_err_cycles", 64'(err_cyc), 64'd0);
    frame_begin();
    rd(8'hAB, 32'hDEADBEEF, 4);
    frame_end();
    fb_valid_async = 1'b0;

    // Retrigger on one register, then two registers acked together
    frame_begin();
    wr(8'h82, 16'h0001);
    wr(8'h82, 16'h0002);
    frame_end();
    cur_img = 64'hABCD_0002_1234_0010;
    check("retrig_reg_data", reg_data, cur_img);
    check("retrig_ack2_cycles", 64'(ack_cyc[2]), 64'(7 + CS));
    frame_begin();
    wr(8'h80, 16'h00AA);
    wr(8'h83, 16'h0055);
    frame_end();
    cur_img = 64'h0055_0002_1234_00AA;
    check("dual_reg_data", reg_data, cur_img);
    check("dual_ack0_cycles", 64'(ack_cyc[0]), 64'd4);
    check("dual_ack3_cycles", 64'(ack_cyc[3]), 64'd4);
    check("dual_ack2_cycles", 64'(ack_cyc[2]), 64'd0);

`ifdef SPI_CMD_CHECKSUM_EN
    frame_begin();
    send(8'h80, 8'hFF); send(8'h10, 8'hFF); send(8'h00, 8'hFF); send(8'h91, 8'hFF);
    frame_end();
    check("csum_bad_reg_data", reg_data, cur_img);
    check("csum_bad_err_cycles", 64'(err_cyc), 64'd1);
    check("csum_bad_ack0_cycles", 64'(ack_cyc[0]), 64'd0);
    frame_begin();
    send(8'h80, 8'hFF); send(8'h10, 8'hFF); send(8'h00, 8'hFF); send(8'h90, 8'hFF);
    frame_end();
    cur_img = 64'h0055_0002_1234_0010;
    check("csum_good_reg_data", reg_data, cur_img);
    check("csum_good_ack0_cycles", 64'(ack_cyc[0]), 64'd4);
    check("csum_good_err_cycles", 64'(err_cyc), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
